// File: rtl/riscv_pkg.sv
// Shared core definitions: default datapath widths, the canonical NOP and the
// fetch FSM state encoding used by fetch, decode and the immediate extractor.
package riscv_pkg;

  localparam int DEFAULT_PC_W  = 64;
  localparam int DEFAULT_INS_W = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset, flush, load, hold on stall, else bubble.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int PC_W  = DEFAULT_PC_W,
  parameter int INS_W = DEFAULT_INS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_stall,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [INS_W-1:0] i_ins,
  output logic             o_valid,
  output logic [PC_W-1:0]  o_pc,
  output logic [INS_W-1:0] o_ins
);

  logic             r_valid;
  logic [PC_W-1:0]  r_pc;
  logic [INS_W-1:0] r_ins;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_ins   <= INS_W'(NOP_INS);
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_ins   <= INS_W'(NOP_INS);
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_ins   <= i_ins;
    end else if (!i_stall) begin
      // Decode consumed the entry and nothing new arrived: insert a bubble.
      r_valid <= 1'b0;
      r_ins   <= INS_W'(NOP_INS);
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_ins   = r_ins;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one imem request at a time, skids a
// response into a one-entry buffer under stall, and honours EX redirects.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter int              INS_W    = DEFAULT_INS_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  // Request: a transfer happens on a cycle where imem_req_valid && imem_req_ready;
  // while valid and not ready, the address holds unless a redirect replaces it.
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [INS_W-1:0] imem_rsp_data,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_ins,
  output fetch_state_t     dbg_state
);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_kill;
  logic [PC_W-1:0]  r_buf_pc;
  logic [INS_W-1:0] r_buf_ins;

  fetch_state_t     w_state_n;
  logic [PC_W-1:0]  w_pc_n;
  logic             w_kill_n;
  logic             w_buf_we;
  logic             w_load;
  logic [PC_W-1:0]  w_load_pc;
  logic [INS_W-1:0] w_load_ins;
  logic [PC_W-1:0]  w_pc_inc;

  assign w_pc_inc = r_pc + PC_W'(4);

  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_kill_n   = r_kill;
    w_buf_we   = 1'b0;
    w_load     = 1'b0;
    w_load_pc  = r_pc;
    w_load_ins = imem_rsp_data;
    unique case (r_state)
      REQ: begin
        if (imem_req_ready) begin
          w_state_n = WAIT;
          if (redirect_valid) w_kill_n = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          w_state_n = REQ;
          if (redirect_valid || r_kill) begin
            // Response belongs to a squashed path; nothing is outstanding now.
            w_kill_n = 1'b0;
          end else if (!stall || !id_valid) begin
            w_load = 1'b1;
            w_pc_n = w_pc_inc;
          end else begin
            w_buf_we  = 1'b1;
            w_pc_n    = w_pc_inc;
            w_state_n = HOLD;
          end
        end else if (redirect_valid) begin
          w_kill_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_state_n = REQ;
        end else if (!stall) begin
          w_load     = 1'b1;
          w_load_pc  = r_buf_pc;
          w_load_ins = r_buf_ins;
          w_state_n  = REQ;
        end
      end
      default: w_state_n = REQ;
    endcase
    if (redirect_valid) w_pc_n = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= REQ;
      r_pc      <= RESET_PC;
      r_kill    <= 1'b0;
      r_buf_pc  <= '0;
      r_buf_ins <= INS_W'(NOP_INS);
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_kill  <= w_kill_n;
      if (w_buf_we) begin
        r_buf_pc  <= r_pc;
        r_buf_ins <= imem_rsp_data;
      end
    end
  end

  assign imem_req_valid = (r_state == REQ) && !reset;
  assign imem_req_addr  = r_pc;
  assign dbg_state      = r_state;

  if_id_reg #(
    .PC_W  (PC_W),
    .INS_W (INS_W)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_load  (w_load),
    .i_stall (stall),
    .i_pc    (w_load_pc),
    .i_ins   (w_load_ins),
    .o_valid (id_valid),
    .o_pc    (id_pc),
    .o_ins   (id_ins)
  );

endmodule
